ifu_fetch: RTL and testbench

- Multicycle instruction fetch unit at the front of the NPC core.
- Holds the architectural PC and fetches through an SRAM-style request/ack port, whose latency is variable.
- Presents {pc, ins} to the IDU over a valid/ready handshake.
- Accepts the next PC from the DNPC/WBU stage through a dnpc_valid strobe.
- A watchdog flags a fetch that never completes.

---
 rtl/ifu_pkg.sv | 18 +
 rtl/ifu_fetch_if.sv | 26 ++
 rtl/ifu_watchdog.sv | 41 ++++
 rtl/ifu_fetch.sv | 133 +++++++++++++
 tb/tb_ifu_fetch.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifu_pkg.sv
// Shared types and defaults for the NPC instruction fetch unit.
package ifu_pkg;

    typedef enum logic [1:0] {
        S_REQ       = 2'd0,
        S_VALID     = 2'd1,
        S_WAIT      = 2'd2,
        S_WAIT_HALT = 2'd3
    } fetch_state_t;

    localparam logic [31:0] IFU_RESET_PC_DEFAULT = 32'h8000_0000;
    localparam int unsigned IFU_TIMEOUT_DEFAULT  = 1024;

    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return addr_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Fetch-unit bus bundle: instruction memory port, IDU handshake and next-PC strobe.
interface ifu_fetch_if #(
    parameter int WIDTH = 32
);
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_ack;
    logic [WIDTH-1:0] imem_rdata;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] ins;
    logic             dnpc_valid;
    logic [WIDTH-1:0] dnpc;

    modport master (
        output imem_req, imem_addr, out_valid, pc, ins,
        input  imem_ack, imem_rdata, out_ready, dnpc_valid, dnpc
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, pc, ins,
        output imem_ack, imem_rdata, out_ready, dnpc_valid, dnpc
    );

endinterface

// File: rtl/ifu_watchdog.sv
// Saturating fetch watchdog: expired is high in the cycle the count of unacked
// request cycles reaches TIMEOUT.
module ifu_watchdog
    import ifu_pkg::*;
#(
    parameter int unsigned TIMEOUT = IFU_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic expired
);

    localparam int unsigned    CW        = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_MAX   = CW'(TIMEOUT);
    localparam logic [CW-1:0]  EXPIRE_AT = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (!run || clr) begin
            count_d = '0;
        end else if (count_q != CNT_MAX) begin
            count_d = count_q + CW'(1);
        end
    end

    assign expired = run && !clr && (count_q >= EXPIRE_AT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// Multicycle instruction fetch unit: REQ -> VALID -> WAIT per instruction.
// Build with IFU_ALIGN_CHECK_EN to halt on misaligned next-PC and expose fetch_fault.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(IFU_RESET_PC_DEFAULT),
    parameter int unsigned      TIMEOUT  = IFU_TIMEOUT_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    ifu_fetch_if.master  bus,
    output logic         fetch_timeout
`ifdef IFU_ALIGN_CHECK_EN
    ,
    output logic         fetch_fault
`endif
);

    fetch_state_t     state_q;
    fetch_state_t     state_d;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] ins_q;
    logic [WIDTH-1:0] ins_d;
    logic             out_valid_q;
    logic             out_valid_d;
    logic             timeout_q;
    logic             timeout_d;
    logic             wd_run;
    logic             wd_clr;
    logic             wd_expired;
`ifdef IFU_ALIGN_CHECK_EN
    logic             fault_q;
    logic             fault_d;
`endif

    assign wd_run = (state_q == S_REQ);
    assign wd_clr = bus.imem_ack;

    if (TIMEOUT != 0) begin : g_wd
        ifu_watchdog #(
            .TIMEOUT (TIMEOUT)
        ) u_watchdog (
            .clk     (clk),
            .rst     (rst),
            .run     (wd_run),
            .clr     (wd_clr),
            .expired (wd_expired)
        );
    end else begin : g_no_wd
        assign wd_expired = 1'b0;
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ins_d     = ins_q;
        timeout_d = timeout_q | wd_expired;
`ifdef IFU_ALIGN_CHECK_EN
        fault_d   = fault_q;
`endif
        case (state_q)
            S_REQ: begin
                if (bus.imem_ack) begin
                    ins_d   = bus.imem_rdata;
                    state_d = S_VALID;
                end
            end
            S_VALID: begin
                if (bus.out_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.dnpc_valid) begin
                    pc_d    = bus.dnpc;
                    state_d = S_REQ;
`ifdef IFU_ALIGN_CHECK_EN
                    if (is_misaligned(bus.dnpc[1:0])) begin
                        fault_d = 1'b1;
                        state_d = S_WAIT_HALT;
                    end
`endif
                end
            end
`ifdef IFU_ALIGN_CHECK_EN
            S_WAIT_HALT: begin
                state_d = S_WAIT_HALT;
            end
`endif
            default: begin
                state_d = S_REQ;
            end
        endcase
        // Registering valid from the next state keeps it glitch-free toward the IDU.
        out_valid_d = (state_d == S_VALID);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            ins_q       <= '0;
            out_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
            fault_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ins_q       <= ins_d;
            out_valid_q <= out_valid_d;
            timeout_q   <= timeout_d;
`ifdef IFU_ALIGN_CHECK_EN
            fault_q     <= fault_d;
`endif
        end
    end

    // The request is gated by rst so memory sees it drop as soon as reset is asserted.
    assign bus.imem_req  = rst && (state_q == S_REQ);
    assign bus.imem_addr = pc_q;
    assign bus.out_valid = out_valid_q;
    assign bus.pc        = pc_q;
    assign bus.ins       = ins_q;
    assign fetch_timeout = timeout_q;
`ifdef IFU_ALIGN_CHECK_EN
    assign fetch_fault   = fault_q;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed self-checking bench for ifu_fetch with a transaction-level model
// compared every cycle plus hand-computed pin checks.
module tb_ifu_fetch;

    localparam int          W      = 32;
    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam int          TO     = 8;
`ifdef IFU_ALIGN_CHECK_EN
    localparam bit          ALIGN_EN = 1'b1;
`else
    localparam bit          ALIGN_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic fetch_timeout;
`ifdef IFU_ALIGN_CHECK_EN
    logic fetch_fault;
`endif

    int vectors     = 0;
    int miscompares = 0;

    ifu_fetch_if #(.WIDTH(W)) bus ();

    ifu_fetch #(
        .WIDTH    (W),
        .RESET_PC (RST_PC),
        .TIMEOUT  (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .fetch_timeout (fetch_timeout)
`ifdef IFU_ALIGN_CHECK_EN
        ,
        .fetch_fault   (fetch_fault)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural model: tracks which phase of the instruction lifecycle we are in
    // and how many consecutive request cycles went unanswered.
    logic        m_init = 1'b0;
    logic        m_fetching;
    logic        m_holding;
    logic        m_halted;
    logic        m_timeout;
    logic        m_fault;
    logic [31:0] m_pc;
    logic [31:0] m_ins;
    int          m_wd;

    always @(posedge clk) begin
        if (!rst) begin
            m_init     <= 1'b1;
            m_fetching <= 1'b1;
            m_holding  <= 1'b0;
            m_halted   <= 1'b0;
            m_timeout  <= 1'b0;
            m_fault    <= 1'b0;
            m_pc       <= RST_PC;
            m_ins      <= '0;
            m_wd       <= 0;
        end else if (m_init) begin
            if (m_fetching) begin
                if (bus.imem_ack) begin
                    m_ins      <= bus.imem_rdata;
                    m_fetching <= 1'b0;
                    m_holding  <= 1'b1;
                    m_wd       <= 0;
                end else begin
                    m_wd <= m_wd + 1;
                    if (TO != 0 && m_wd + 1 >= TO) m_timeout <= 1'b1;
                end
            end else if (m_holding) begin
                if (bus.out_ready) m_holding <= 1'b0;
            end else if (!m_halted && bus.dnpc_valid) begin
                m_pc <= bus.dnpc;
                if (ALIGN_EN && bus.dnpc[1:0] != 2'b00) begin
                    m_halted <= 1'b1;
                    m_fault  <= 1'b1;
                end else begin
                    m_fetching <= 1'b1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic compareModel();
        if (m_init) begin
            checkOutput("imem_req",      32'(bus.imem_req),  32'(rst & m_fetching));
            checkOutput("imem_addr",     bus.imem_addr,      m_pc);
            checkOutput("out_valid",     32'(bus.out_valid), 32'(m_holding));
            checkOutput("pc",            bus.pc,             m_pc);
            checkOutput("ins",           bus.ins,            m_ins);
            checkOutput("fetch_timeout", 32'(fetch_timeout), 32'(m_timeout));
`ifdef IFU_ALIGN_CHECK_EN
            checkOutput("fetch_fault",   32'(fetch_fault),   32'(m_fault));
`endif
        end
    endtask

    task automatic applyStimulus(input logic r, input logic ack, input logic [31:0] rdata,
                                 input logic rdy, input logic dv, input logic [31:0] npc);
        rst            = r;
        bus.imem_ack   = ack;
        bus.imem_rdata = rdata;
        bus.out_ready  = rdy;
        bus.dnpc_valid = dv;
        bus.dnpc       = npc;
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
        compareModel();
        @(posedge clk);
        #1;
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        checkOutput("rst_req",     32'(bus.imem_req),  32'h0);
        checkOutput("rst_valid",   32'(bus.out_valid), 32'h0);
        checkOutput("rst_pc",      bus.pc,             32'h8000_0000);
        checkOutput("rst_ins",     bus.ins,            32'h0);
        checkOutput("rst_timeout", 32'(fetch_timeout), 32'h0);
        tick();

        // Zero-wait fetch
        applyStimulus(1'b1, 1'b1, 32'h0000_0413, 1'b1, 1'b0, 32'h0);
        checkOutput("zw_req",  32'(bus.imem_req), 32'h1);
        checkOutput("zw_addr", bus.imem_addr,     32'h8000_0000);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checkOutput("zw_valid", 32'(bus.out_valid), 32'h1);
        checkOutput("zw_ins",   bus.ins,            32'h0000_0413);
        checkOutput("zw_pc",    bus.pc,             32'h8000_0000);
        tick();
        checkOutput("zw_valid_drop", 32'(bus.out_valid), 32'h0);
        checkOutput("zw_req_idle",   32'(bus.imem_req),  32'h0);
        tick();

        // Ack delayed by 5 cycles
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0004);
        tick();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, (i == 5), (i == 5) ? 32'h0010_0093 : 32'h0, 1'b0, 1'b0, 32'h0);
            checkOutput("dly_req",   32'(bus.imem_req),  32'h1);
            checkOutput("dly_addr",  bus.imem_addr,      32'h8000_0004);
            checkOutput("dly_valid", 32'(bus.out_valid), 32'h0);
            tick();
        end
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("dly_valid_rise", 32'(bus.out_valid), 32'h1);
        checkOutput("dly_ins",        bus.ins,            32'h0010_0093);

        // IDU stall with an illegal dnpc pulse in S_VALID
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, (i == 1), 32'h8000_0100);
            tick();
            checkOutput("stall_pc",    bus.pc,             32'h8000_0004);
            checkOutput("stall_ins",   bus.ins,            32'h0010_0093);
            checkOutput("stall_valid", 32'(bus.out_valid), 32'h1);
        end
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("stray_ack_ins", bus.ins,            32'h0010_0093);
        checkOutput("stray_ack_req", 32'(bus.imem_req),  32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0100);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("dnpc_req",  32'(bus.imem_req), 32'h1);
        checkOutput("dnpc_addr", bus.imem_addr,     32'h8000_0100);

        // Reset in the middle of a request with an ack pending
        tick();
        applyStimulus(1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
        checkOutput("midrst_req", 32'(bus.imem_req), 32'h0);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("restart_req",   32'(bus.imem_req),  32'h1);
        checkOutput("restart_addr",  bus.imem_addr,      32'h8000_0000);
        checkOutput("restart_valid", 32'(bus.out_valid), 32'h0);
        checkOutput("restart_ins",   bus.ins,            32'h0);
        tick();
        tick();
        checkOutput("stale_ack_valid", 32'(bus.out_valid), 32'h0);
        applyStimulus(1'b1, 1'b1, 32'h0000_0013, 1'b1, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checkOutput("restart_ins_done", bus.ins, 32'h0000_0013);
        tick();

        // Watchdog with TIMEOUT=8
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0200);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            checkOutput("wd_req", 32'(bus.imem_req), 32'h1);
            if (k == 7) checkOutput("wd_before", 32'(fetch_timeout), 32'h0);
            if (k == 8) checkOutput("wd_fire",   32'(fetch_timeout), 32'h1);
        end
        applyStimulus(1'b1, 1'b1, 32'h0000_0093, 1'b1, 1'b0, 32'h0);
        tick();
        checkOutput("wd_late_sticky", 32'(fetch_timeout), 32'h1);
        checkOutput("wd_late_valid",  32'(bus.out_valid), 32'h1);
        checkOutput("wd_late_ins",    bus.ins,            32'h0000_0093);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        tick();
        checkOutput("wd_still_sticky", 32'(fetch_timeout), 32'h1);

        // Misaligned next PC
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0102);
        tick();
`ifdef IFU_ALIGN_CHECK_EN
        checkOutput("fault_set",   32'(fetch_fault),   32'h1);
        checkOutput("fault_pc",    bus.pc,             32'h8000_0102);
        checkOutput("fault_req",   32'(bus.imem_req),  32'h0);
        checkOutput("fault_valid", 32'(bus.out_valid), 32'h0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 32'h0000_0013, 1'b1, 1'b1, 32'h8000_0000);
            tick();
            checkOutput("halt_req",   32'(bus.imem_req), 32'h0);
            checkOutput("halt_fault", 32'(fetch_fault),  32'h1);
        end
`else
        applyStimulus(1'b1, 1'b1, 32'h0000_0513, 1'b1, 1'b0, 32'h0);
        checkOutput("misal_req",  32'(bus.imem_req), 32'h1);
        checkOutput("misal_addr", bus.imem_addr,     32'h8000_0102);
        tick();
        checkOutput("misal_ins",   bus.ins,            32'h0000_0513);
        checkOutput("misal_valid", 32'(bus.out_valid), 32'h1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        tick();
`endif

        // Final reset clears sticky flags
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("final_timeout", 32'(fetch_timeout), 32'h0);
        checkOutput("final_pc",      bus.pc,             32'h8000_0000);
        checkOutput("final_req",     32'(bus.imem_req),  32'h1);
`ifdef IFU_ALIGN_CHECK_EN
        checkOutput("final_fault",   32'(fetch_fault),   32'h0);
`endif
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
